// File: rtl/bcd_denormalize_pkg.sv
// Shared definitions for the low-frequency counter BCD datapath:
// digit geometry, display/arithmetic digit counts and the sequencer states
// used by both the normaliser and the denormaliser.
package bcd_denormalize_pkg;

  // Display digit: 4-bit BCD value plus the "units digit here" flag in bit 4.
  localparam int DIGW     = 5;
  localparam int FLAG_BIT = 4;
  localparam int BCDW     = 4;

  // Display width, arithmetic width and units-digit position in the datapath.
  // The units position equals NOUT-NIN so a flag on the top display digit
  // can be walked all the way down without dropping any non-zero digit.
  localparam int NIN    = 6;
  localparam int NOUT   = 11;
  localparam int DP_POS = NOUT - NIN;

  // Width of a display digit index (0..NIN-1).
  localparam int IDXW = $clog2(NIN);

  // Sequencer states shared with the normaliser.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_dp_locate.sv
// Decimal-point locator: looks at the flag bits of the display digits and
// reports whether exactly one is set and, if so, which digit carries it.
module bcd_dp_locate
  import bcd_denormalize_pkg::*;
(
  input  logic [NIN-1:0]  flags_i,
  output logic            oneFlag_o,
  output logic [IDXW-1:0] flagIdx_o
);

  localparam int CW = $clog2(NIN + 1);

  logic [CW-1:0] flagCount;

  // Count the flags and remember the position of the highest one seen.
  always_comb begin
    flagCount = '0;
    flagIdx_o = '0;
    for (int k = 0; k < NIN; k++) begin
      if (flags_i[k]) begin
        flagCount = flagCount + CW'(1);
        flagIdx_o = IDXW'(k);
      end
    end
    oneFlag_o = (flagCount == CW'(1));
  end

endmodule

// File: rtl/bcd_denormalize.sv
// BCD denormaliser: takes six left-justified display digits whose flag bit
// marks the units digit and right-justifies them into the 11-digit
// fixed-point arithmetic format (units at DP_POS, five fractional digits),
// moving one digit per clock until the flagged digit lands on DP_POS.
module bcd_denormalize
  import bcd_denormalize_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [DIGW*NIN-1:0]  din_i,
  output logic [BCDW*NOUT-1:0] dout_o,
  output logic                 busy_o,
  output logic                 doneTick_o,
  output logic                 flagErr_o
);

  localparam int WORKW = DIGW * NOUT;
  localparam int DPFLAG = DIGW * DP_POS + FLAG_BIT;

  state_e                state_q, state_d;
  logic [WORKW-1:0]      work_q, work_d;
  logic [BCDW*NOUT-1:0]  dout_q, dout_d;
  logic                  flagErr_q, flagErr_d;
  logic                  doneTick_q, doneTick_d;
  logic [IDXW-1:0]       shiftsLeft_q, shiftsLeft_d;

  logic [NIN-1:0]        dinFlags;
  logic                  oneFlag;
  logic [IDXW-1:0]       flagIdx;
  logic [WORKW-1:0]      loadWork;
  logic [BCDW*NOUT-1:0]  workBcd;

  // Gather the per-digit decimal-point flags from the display word.
  always_comb begin
    dinFlags = '0;
    for (int k = 0; k < NIN; k++) begin
      dinFlags[k] = din_i[DIGW*k + FLAG_BIT];
    end
  end

  bcd_dp_locate u_locate (
    .flags_i   (dinFlags),
    .oneFlag_o (oneFlag),
    .flagIdx_o (flagIdx)
  );

  // Display digits sit at the top of the work register, fraction cleared.
  assign loadWork = {din_i, {(DIGW*DP_POS){1'b0}}};

  // Strip the flag bits to form the arithmetic-side BCD view of the work register.
  always_comb begin
    workBcd = '0;
    for (int m = 0; m < NOUT; m++) begin
      workBcd[BCDW*m +: BCDW] = work_q[DIGW*m +: BCDW];
    end
  end

  // Sequencer next state: load in IDLE, walk down in SHIFT, pulse in DONE.
  // The shift budget taken from the located flag index bounds the walk
  // even if the work register were somehow corrupted mid-shift.
  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    dout_d       = dout_q;
    flagErr_d    = flagErr_q;
    doneTick_d   = 1'b0;
    shiftsLeft_d = shiftsLeft_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (oneFlag) begin
            work_d       = loadWork;
            shiftsLeft_d = flagIdx;
            state_d      = SHIFT;
          end else begin
            work_d       = '0;
            shiftsLeft_d = '0;
            dout_d       = '0;
            flagErr_d    = 1'b1;
            doneTick_d   = 1'b1;
            state_d      = DONE;
          end
        end
      end
      SHIFT: begin
        if (work_q[DPFLAG] || (shiftsLeft_q == '0)) begin
          dout_d     = workBcd;
          flagErr_d  = 1'b0;
          doneTick_d = 1'b1;
          state_d    = DONE;
        end else begin
          work_d       = {{DIGW{1'b0}}, work_q[WORKW-1:DIGW]};
          shiftsLeft_d = shiftsLeft_q - IDXW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, work and output registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      work_q       <= '0;
      dout_q       <= '0;
      flagErr_q    <= 1'b0;
      doneTick_q   <= 1'b0;
      shiftsLeft_q <= '0;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      dout_q       <= dout_d;
      flagErr_q    <= flagErr_d;
      doneTick_q   <= doneTick_d;
      shiftsLeft_q <= shiftsLeft_d;
    end
  end

  assign dout_o     = dout_q;
  assign flagErr_o  = flagErr_q;
  assign doneTick_o = doneTick_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_denormalize.sv
// Bench for bcd_denormalize: directed table of corner cases, a start
// re-pulse and a mid-shift reset, then randomised requests compared with a
// behavioural model that scales the display value by powers of ten.
module tb_bcd_denormalize;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [29:0] din;
  logic [43:0] dout;
  logic        busy;
  logic        doneTick;
  logic        flagErr;

  int checks;
  int errors;

  typedef struct {
    logic [23:0] bcd;
    logic [5:0]  flags;
    logic [43:0] expDout;
    logic        expErr;
    int          expLat;
    int          repulse;
  } vec_t;

  vec_t vecs[6];

  bcd_denormalize dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .din_i      (din),
    .dout_o     (dout),
    .busy_o     (busy),
    .doneTick_o (doneTick),
    .flagErr_o  (flagErr)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] packDin(input logic [23:0] bcd, input logic [5:0] flags);
    logic [29:0] d;
    d = '0;
    for (int k = 0; k < 6; k++) begin
      d[5*k +: 5] = {flags[k], bcd[4*k +: 4]};
    end
    return d;
  endfunction

  // Reference: with one flag at display digit j the value is the display
  // number shifted so digit j sits at the units position (digit 5).
  task automatic modelRun(input logic [23:0] bcd, input logic [5:0] flags,
                          output logic [43:0] expDout, output logic expErr,
                          output int expLat);
    int j;
    logic [43:0] wide;
    if ($countones(flags) != 1) begin
      expDout = '0;
      expErr  = 1'b1;
      expLat  = 1;
    end else begin
      j = 0;
      for (int k = 0; k < 6; k++) if (flags[k]) j = k;
      wide    = {20'd0, bcd};
      expDout = wide << (4 * (5 - j));
      expErr  = 1'b0;
      expLat  = 2 + j;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] bcd, input logic [5:0] flags, input int repulse,
                               output logic [43:0] gotDout, output logic gotErr,
                               output int lat, output int doneCnt, output int busyCnt);
    lat     = 0;
    doneCnt = 0;
    busyCnt = 0;
    gotDout = '0;
    gotErr  = 1'b0;
    @(negedge clk);
    din   = packDin(bcd, flags);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 12; c++) begin
      start = (c == repulse);
      if (doneTick) begin
        doneCnt++;
        if (lat == 0) begin
          lat     = c;
          gotDout = dout;
          gotErr  = flagErr;
        end
      end
      if (busy) busyCnt++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [23:0] bcd, input logic [5:0] flags,
                             input int repulse, input logic [43:0] expDout,
                             input logic expErr, input int expLat);
    logic [43:0] gotDout;
    logic        gotErr;
    int          lat, doneCnt, busyCnt;
    applyStimulus(bcd, flags, repulse, gotDout, gotErr, lat, doneCnt, busyCnt);
    checkOutput($sformatf("%s_dout", tag), 64'(gotDout), 64'(expDout));
    checkOutput($sformatf("%s_flagErr", tag), 64'(gotErr), 64'(expErr));
    checkOutput($sformatf("%s_latency", tag), 64'(lat), 64'(expLat));
    checkOutput($sformatf("%s_doneCount", tag), 64'(doneCnt), 64'd1);
    checkOutput($sformatf("%s_busyCycles", tag), 64'(busyCnt), 64'(expLat));
    checkOutput($sformatf("%s_doutHold", tag), 64'(dout), 64'(expDout));
  endtask

  // Main sequence: reset, directed table, mid-shift reset, random requests.
  initial begin
    logic [23:0] rBcd;
    logic [5:0]  rFlags;
    logic [43:0] mDout;
    logic        mErr;
    int          mLat;
    int          lateDone;

    checks = 0;
    errors = 0;

    vecs[0] = '{24'h123456, 6'b000001, 44'h12345600000, 1'b0, 2, 0};
    vecs[1] = '{24'h987654, 6'b001000, 44'h00098765400, 1'b0, 5, 0};
    vecs[2] = '{24'h100000, 6'b100000, 44'h00000100000, 1'b0, 7, 0};
    vecs[3] = '{24'h123456, 6'b000000, 44'h00000000000, 1'b1, 1, 0};
    vecs[4] = '{24'h123456, 6'b010010, 44'h00000000000, 1'b1, 1, 0};
    vecs[5] = '{24'h987654, 6'b001000, 44'h00098765400, 1'b0, 5, 2};

    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_doneTick", 64'(doneTick), 64'd0);
    checkOutput("reset_flagErr", 64'(flagErr), 64'd0);
    checkOutput("reset_dout", 64'(dout), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].flags, vecs[i].repulse,
                  vecs[i].expDout, vecs[i].expErr, vecs[i].expLat);
    end

    // Reset in the middle of a shift must abort silently.
    @(negedge clk);
    din   = packDin(24'h987654, 6'b001000);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midShift_busyBefore", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset_busy", 64'(busy), 64'd0);
    checkOutput("midReset_doneTick", 64'(doneTick), 64'd0);
    checkOutput("midReset_dout", 64'(dout), 64'd0);
    checkOutput("midReset_flagErr", 64'(flagErr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lateDone = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (doneTick || busy) lateDone++;
    end
    checkOutput("midReset_noDone", 64'(lateDone), 64'd0);
    runAndCheck("afterReset", vecs[0].bcd, vecs[0].flags, 0,
                vecs[0].expDout, vecs[0].expErr, vecs[0].expLat);

    // Randomised requests, roughly one in ten with a bad flag count.
    for (int n = 0; n < 1000; n++) begin
      rBcd = 24'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rFlags = 6'($urandom);
        while ($countones(rFlags) == 1) rFlags = 6'($urandom);
      end else begin
        rFlags = 6'b000001 << $urandom_range(0, 5);
      end
      modelRun(rBcd, rFlags, mDout, mErr, mLat);
      runAndCheck($sformatf("rand%0d", n), rBcd, rFlags, 0, mDout, mErr, mLat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
